// File: rtl/fetch_pkg.sv
// Shared defines for the fetch slice: word width, NOP encoding, opcodes.
// Also holds the {pc, instr} bundle carried through the fetch buffer.
`ifndef WORD
`define WORD 31:0
`endif

package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic word_t pc_next(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries.
// Flush empties it in one edge; push is ignored when full without a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    // Pointer, count and storage next-state.
    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty   = (cnt_q == '0);
        count   = cnt_q;
        rdata   = mem_q[rptr_q];
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch.sv
// Credit-based instruction fetch stage feeding decode via fetch_fifo.
// Define FETCH_BYPASS_EN to let a response skip an empty buffer.
module fetch
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         redirectE,
    input  logic [`WORD] pcTargetE,
    output logic         imemReq,
    output logic [`WORD] imemAddr,
    input  logic         imemGnt,
    input  logic         imemRvalid,
    input  logic [`WORD] imemRdata,
    output logic [`WORD] pcD,
    output logic [`WORD] instrD,
    output logic         validD
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    word_t          pc_f_q, pc_f_d;
    word_t          rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  drop_q, drop_d;
    word_t          dec_pc_q, dec_pc_d;
    word_t          dec_instr_q, dec_instr_d;
    logic           dec_valid_q, dec_valid_d;

    logic           grant;
    logic           rsp_drop;
    logic           rsp_use;
    logic           credit_ok;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_wdata;
    fetch_entry_t   fifo_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirectE),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Request side: credits, PC advance, drop and response-PC tracking.
    always_comb begin
        rsp_drop  = imemRvalid && (drop_q != '0);
        rsp_use   = imemRvalid && !rsp_drop && !redirectE;
        credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_C;
        imemReq   = reset && !redirectE && credit_ok;
        imemAddr  = pc_f_q;
        grant     = imemReq && imemGnt;
        pc_f_d    = pc_f_q;
        rsp_pc_d  = rsp_pc_q;
        drop_d    = drop_q;
        outst_d   = outst_q + CW'(grant) - CW'(imemRvalid);
        if (redirectE) begin
            pc_f_d   = pcTargetE;
            rsp_pc_d = pcTargetE;
            drop_d   = outst_q - CW'(imemRvalid);
        end else begin
            if (grant) begin
                pc_f_d = pc_next(pc_f_q);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_use) begin
                rsp_pc_d = pc_next(rsp_pc_q);
            end
        end
    end

    // Decode side: buffer push/pop, optional bypass, redirect flush.
    always_comb begin
        fifo_wdata  = '{pc: rsp_pc_q, instr: imemRdata};
        fifo_pop    = 1'b0;
        fifo_push   = 1'b0;
        dec_pc_d    = dec_pc_q;
        dec_instr_d = dec_instr_q;
        dec_valid_d = dec_valid_q;
        if (redirectE) begin
            dec_valid_d = 1'b0;
            dec_instr_d = INSTR_NOP;
        end else if (en) begin
            if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                dec_pc_d    = fifo_rdata.pc;
                dec_instr_d = fifo_rdata.instr;
                dec_valid_d = 1'b1;
                fifo_push   = rsp_use;
            end else begin
`ifdef FETCH_BYPASS_EN
                if (rsp_use) begin
                    dec_pc_d    = rsp_pc_q;
                    dec_instr_d = imemRdata;
                    dec_valid_d = 1'b1;
                end else begin
                    dec_valid_d = 1'b0;
                end
`else
                dec_valid_d = 1'b0;
                fifo_push   = rsp_use && !fifo_full;
`endif
            end
        end else begin
            fifo_push = rsp_use && !fifo_full;
        end
    end

    always_comb begin
        pcD    = dec_pc_q;
        instrD = dec_instr_q;
        validD = dec_valid_q;
    end

    // Fetch and decode-side state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f_q      <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            dec_pc_q    <= '0;
            dec_instr_q <= INSTR_NOP;
            dec_valid_q <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            rsp_pc_q    <= rsp_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
            dec_valid_q <= dec_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with an in-order memory model.
// Covers streaming, en stall, redirect drop, grant stall and reset.
module tb_fetch;

    import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam int B31 = 1;
`else
    localparam int B31 = 3;
`endif
    localparam int BND = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        redirectE;
    logic [31:0] pcTargetE;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    logic        gntEn;
    logic        hold;
    logic [31:0] mq [8];
    logic [2:0]  wp, rp;
    logic [3:0]  mc;
    int          gcnt = 0;

    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] expPc;

    always #5 clk = ~clk;

    fetch u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .redirectE  (redirectE),
        .pcTargetE  (pcTargetE),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD)
    );

    function automatic logic [31:0] inst(input logic [31:0] a);
        return {a[23:0], 8'h00} ^ 32'h5A00_0033;
    endfunction

    assign imemGnt    = gntEn;
    assign imemRvalid = reset && !hold && (mc != 4'd0);
    assign imemRdata  = inst(mq[rp]);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            mc <= '0;
        end else begin
            if (imemReq && imemGnt) begin
                mq[wp] <= imemAddr;
                wp     <= wp + 3'd1;
            end
            if (imemRvalid) begin
                rp <= rp + 3'd1;
            end
            mc <= mc + 4'(imemReq && imemGnt) - 4'(imemRvalid);
        end
    end

    always @(posedge clk) begin
        gcnt <= gcnt + int'(imemReq && imemGnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic take_beat(input string tag);
        chk({tag, "_pc"}, pcD, expPc);
        chk({tag, "_instr"}, instrD, inst(expPc));
        expPc = expPc + 32'd4;
    endtask

    task automatic beat(input int bound, input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            step();
            if (validD) got = 1'b1;
        end
        chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
        if (got) take_beat(tag);
    endtask

    task automatic drain(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            if (validD) take_beat(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        logic [31:0] a0;
        int          g0;

        reset     = 1'b0;
        en        = 1'b1;
        redirectE = 1'b0;
        pcTargetE = '0;
        gntEn     = 1'b1;
        hold      = 1'b0;
        expPc     = '0;

        repeat (2) step();
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_valid", {31'd0, validD}, 32'd0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_instrD", instrD, INSTR_NOP);
        chk("rst_addr", imemAddr, 32'h0);

        reset = 1'b1;
        #1;
        chk("first_req", {31'd0, imemReq}, 32'd1);
        chk("first_addr", imemAddr, 32'h0);
        step();
        chk("edge1_valid", {31'd0, validD}, 32'd0);
        chk("edge1_addr", imemAddr, 32'h4);
        step();
`ifdef FETCH_BYPASS_EN
        chk("edge2_valid", {31'd0, validD}, 32'd1);
        take_beat("edge2");
`else
        chk("edge2_valid", {31'd0, validD}, 32'd0);
        step();
        chk("edge3_valid", {31'd0, validD}, 32'd1);
        take_beat("edge3");
`endif
        beat(B31, "stream");
        beat(B31, "stream");
        beat(B31, "stream");

        held = expPc - 32'd4;
        g0   = gcnt;
        en   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_pc", pcD, held);
            chk("hold_valid", {31'd0, validD}, 32'd1);
        end
        chk("extra_req_le2", {31'd0, (gcnt - g0) <= 2}, 32'd1);
        en = 1'b1;
        beat(BND, "resume");
        beat(BND, "resume");
        beat(BND, "resume");

        hold = 1'b1;
        drain(6, "pre_redir");
        chk("redir_pending", {28'd0, mc}, 32'd2);
        chk("redir_credit", {31'd0, imemReq}, 32'd0);
        chk("redir_pre_valid", {31'd0, validD}, 32'd0);
        redirectE = 1'b1;
        pcTargetE = 32'h100;
        hold      = 1'b0;
        #1;
        chk("redir_noreq", {31'd0, imemReq}, 32'd0);
        step();
        redirectE = 1'b0;
        chk("redir_valid", {31'd0, validD}, 32'd0);
        chk("redir_nop", instrD, INSTR_NOP);
        chk("redir_addr", imemAddr, 32'h100);
        expPc = 32'h100;
        beat(BND, "target");
        beat(BND, "target");

        gntEn = 1'b0;
        a0    = imemAddr;
        for (int k = 0; k < 4; k++) begin
            step();
            if (validD) take_beat("stall");
            chk("stall_addr", imemAddr, a0);
        end
        chk("stall_drained", {31'd0, validD}, 32'd0);
        chk("stall_req", {31'd0, imemReq}, 32'd1);
        gntEn = 1'b1;
        beat(BND, "unstall");

        gntEn = 1'b0;
        drain(3, "pre_rst");
        gntEn = 1'b1;
        step();
        chk("one_pending", {28'd0, mc}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imemReq}, 32'd0);
        chk("midrst_valid", {31'd0, validD}, 32'd0);
        chk("midrst_pcD", pcD, 32'h0);
        chk("midrst_instrD", instrD, INSTR_NOP);
        chk("midrst_addr", imemAddr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expPc = 32'h0;
        #1;
        chk("rel_addr", imemAddr, 32'h0);
        beat(BND, "after_rst");
        beat(BND, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction-buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, meaning an asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1, meaning the hazard-unit enable; 0 holds the decode-side outputs.
REQ-006 SHALL have port redirectE, input, 1, meaning a taken branch or jump resolved in execute.
REQ-007 SHALL have port pcTargetE, input, `WORD, meaning the redirect target address.
REQ-008 SHALL have port imemReq, output, 1, meaning an instruction-memory request is valid.
REQ-009 SHALL have port imemAddr, output, `WORD, meaning the request address.
REQ-010 SHALL have port imemGnt, input, 1, meaning the request is accepted this cycle.
REQ-011 SHALL have port imemRvalid, input, 1, meaning response data is valid; responses arrive in order, at least 1 cycle after grant.
REQ-012 SHALL have port imemRdata, input, `WORD, meaning the response instruction word.
REQ-013 SHALL have ports pcD, output, `WORD; instrD, output, `WORD; validD, output, 1; together these form the decode-stage input.

Function
REQ-014 SHALL hold fetch PC pcF, drive imemAddr=pcF, and assert imemReq iff redirectE=0 and (outstanding + fifoCount) < FIFO_DEPTH.
REQ-015 SHALL, on imemReq&&imemGnt, increment pcF by 4 (wrap modulo 2^`WORD`) and increment outstanding.
REQ-016 SHALL, on an accepted imemRvalid, decrement outstanding and push {pc, imemRdata} to the buffer; pc is tracked as the address of the oldest outstanding request.
REQ-017 SHALL keep imemAddr stable while imemReq=1 and imemGnt=0.
REQ-018 SHALL, when en=1, load pcD/instrD from the buffer head with validD=1 and pop, or set validD=0 if the buffer is empty.
REQ-019 SHALL, when en=0, hold pcD, instrD and validD, while requests and buffering continue within credit limits.
REQ-020 SHALL, on redirectE=1 (which has priority over en), set pcF=pcTargetE, flush the buffer, clear validD and set instrD=NOP on the next edge.
REQ-021 SHALL, on redirect, load the drop counter with outstanding minus any response arriving that same cycle, discard each later response while the drop counter is non-zero (decrementing it), and never push discarded responses.
REQ-022 SHALL accept a redirect and a response in the same cycle with the response discarded, and a redirect and a grant in the same cycle cannot occur because imemReq=0.
REQ-023 SHALL never overflow the buffer; credit accounting (REQ-014) guarantees space for every in-flight response.
REQ-024 SHALL, with the buffer full and en=1 and a response arriving, pop and push in the same cycle.

Reset
REQ-025 SHALL, while reset=0, asynchronously set pcF=RESET_PC, outstanding=0, drop=0, buffer empty, validD=0, pcD=0, instrD=32'h0000_0013 (NOP), and imemReq=0.
REQ-026 SHALL, when reset is asserted mid-transaction, abandon in-flight responses; the memory side is reset by the same signal.

Configuration
REQ-027 SHALL, with FETCH_BYPASS_EN defined, write a response directly into pcD/instrD with validD=1 when the buffer is empty, en=1, redirectE=0 and the response is not dropped, giving grant-to-validD latency of 2 edges.
REQ-028 SHALL, without FETCH_BYPASS_EN, route every response through the buffer, giving a minimum grant-to-validD latency of 3 edges, with identical instruction order.

Structure
REQ-029 SHALL take `WORD and the NOP encoding (INSTR_NOP) from the shared defines package alongside the OPCODE constants.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo, a synchronous FIFO of {pc, instr} with push, pop, full, empty and count.

Verification
REQ-031 SHALL cover this scenario: reset release, and memory grants every cycle with 1-cycle response -> pcD sequence 0,4,8,12 on consecutive cycles, validD continuous.
REQ-032 SHALL cover this scenario: en=0 for 3 cycles with FIFO_DEPTH=2 -> at most 2 extra requests issued, pcD held, and no instruction lost or duplicated after en=1.
REQ-033 SHALL cover this scenario: redirectE=1, pcTargetE=32'h100, with 2 responses outstanding -> both responses dropped and next validD carries pcD=32'h100.
REQ-034 SHALL cover this scenario: imemGnt held 0 for 4 cycles -> imemAddr stable and validD=0 once the buffer drains.
REQ-035 SHALL cover this scenario: reset asserted with 1 request outstanding -> outputs at reset values immediately; after release the first fetch is at RESET_PC.
REQ-036 SHALL cover this scenario: both builds, single request at 32'h0 -> validD at edge 2 (FETCH_BYPASS_EN) versus edge 3 after grant.
